// File: rtl/asrv32_decoder.sv
// asrv32_decoder: registered RV32I instruction-decode stage between fetch and
// execute. Produces operand addresses, the immediate, a one-hot opcode class
// and the one-hot ALU operation vector that drives asrv32_alu.
`timescale 1ns/1ps
module asrv32_decoder #(
  parameter  int OPCODE_WIDTH = 11,
  localparam int ALU_WIDTH    = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [31:0]             i_inst,
  input  logic [31:0]             i_pc,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_valid,
  output logic [ALU_WIDTH-1:0]    o_alu,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [4:0]              o_rs1_addr,
  output logic [4:0]              o_rs2_addr,
  output logic [4:0]              o_rd_addr,
  output logic [31:0]             o_imm,
  output logic [2:0]              o_funct3,
  output logic [31:0]             o_pc,
  output logic                    o_illegal,
  output logic                    o_ecall,
  output logic                    o_ebreak
);

  // ALU operation indices shared with asrv32_alu
  localparam int ADD = 0, SUB = 1, SLT = 2, SLTU = 3, XOR = 4, OR = 5, AND = 6;
  localparam int SLL = 7, SRL = 8, SRA = 9, EQ = 10, NEQ = 11, GE = 12, GEU = 13;

  // Opcode class bit positions
  localparam int C_RTYPE = 0, C_ITYPE = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYSTEM = 9;
  localparam int C_FENCE = 10;

  // Register/immediate funct3 map shared by R-type and I-type arithmetic
  function automatic logic [ALU_WIDTH-1:0] alu_arith(input logic [2:0] f3);
    logic [ALU_WIDTH-1:0] v;
    v = '0;
    case (f3)
      3'b000:  v[ADD]  = 1'b1;
      3'b001:  v[SLL]  = 1'b1;
      3'b010:  v[SLT]  = 1'b1;
      3'b011:  v[SLTU] = 1'b1;
      3'b100:  v[XOR]  = 1'b1;
      3'b101:  v[SRL]  = 1'b1;
      3'b110:  v[OR]   = 1'b1;
      default: v[AND]  = 1'b1;
    endcase
    return v;
  endfunction

  // Branch comparison map; all-zero marks the reserved encodings
  function automatic logic [ALU_WIDTH-1:0] alu_branch(input logic [2:0] f3);
    logic [ALU_WIDTH-1:0] v;
    v = '0;
    case (f3)
      3'b000:  v[EQ]   = 1'b1;
      3'b001:  v[NEQ]  = 1'b1;
      3'b100:  v[SLT]  = 1'b1;
      3'b101:  v[GE]   = 1'b1;
      3'b110:  v[SLTU] = 1'b1;
      3'b111:  v[GEU]  = 1'b1;
      default: v       = '0;
    endcase
    return v;
  endfunction

  function automatic logic [ALU_WIDTH-1:0] alu_onehot(input int idx);
    logic [ALU_WIDTH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        capture;

  assign f3    = i_inst[14:12];
  assign f7    = i_inst[31:25];
  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  assign o_ready = !o_valid || !i_stall;
  assign capture = i_valid && o_ready && !i_flush;

  logic [ALU_WIDTH-1:0]    dec_alu;
  logic [OPCODE_WIDTH-1:0] dec_cls;
  logic [31:0]             dec_imm;
  logic [4:0]              dec_rs1, dec_rs2, dec_rd;
  logic                    dec_ill, dec_ecall, dec_ebreak;

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_alu    = '0;
    dec_cls    = '0;
    dec_imm    = '0;
    dec_ill    = 1'b0;
    dec_ecall  = 1'b0;
    dec_ebreak = 1'b0;
    if (i_inst[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (i_inst[6:2])
        5'b01100: begin
          if (f7 == 7'h00) begin
            dec_cls[C_RTYPE] = 1'b1;
            dec_alu          = alu_arith(f3);
          end else if (f7 == 7'h20 && f3 == 3'b000) begin
            dec_cls[C_RTYPE] = 1'b1;
            dec_alu          = alu_onehot(SUB);
          end else if (f7 == 7'h20 && f3 == 3'b101) begin
            dec_cls[C_RTYPE] = 1'b1;
            dec_alu          = alu_onehot(SRA);
          end else begin
            dec_ill = 1'b1;
          end
        end
        5'b00100: begin
          // Only the shift-immediates constrain the upper seven bits
          if ((f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) begin
            dec_ill = 1'b1;
          end else begin
            dec_cls[C_ITYPE] = 1'b1;
            dec_alu          = (f3 == 3'b101 && f7 == 7'h20) ? alu_onehot(SRA) : alu_arith(f3);
            dec_imm          = imm_i;
          end
        end
        5'b00000: begin
          if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
            dec_ill = 1'b1;
          end else begin
            dec_cls[C_LOAD] = 1'b1;
            dec_alu         = alu_onehot(ADD);
            dec_imm         = imm_i;
          end
        end
        5'b01000: begin
          if (f3 > 3'b010) begin
            dec_ill = 1'b1;
          end else begin
            dec_cls[C_STORE] = 1'b1;
            dec_alu          = alu_onehot(ADD);
            dec_imm          = imm_s;
          end
        end
        5'b11000: begin
          if (alu_branch(f3) == '0) begin
            dec_ill = 1'b1;
          end else begin
            dec_cls[C_BRANCH] = 1'b1;
            dec_alu           = alu_branch(f3);
            dec_imm           = imm_b;
          end
        end
        5'b11011: begin
          dec_cls[C_JAL] = 1'b1;
          dec_alu        = alu_onehot(ADD);
          dec_imm        = imm_j;
        end
        5'b11001: begin
          if (f3 != 3'b000) begin
            dec_ill = 1'b1;
          end else begin
            dec_cls[C_JALR] = 1'b1;
            dec_alu         = alu_onehot(ADD);
            dec_imm         = imm_i;
          end
        end
        5'b01101: begin
          dec_cls[C_LUI] = 1'b1;
          dec_alu        = alu_onehot(ADD);
          dec_imm        = imm_u;
        end
        5'b00101: begin
          dec_cls[C_AUIPC] = 1'b1;
          dec_alu          = alu_onehot(ADD);
          dec_imm          = imm_u;
        end
        5'b11100: begin
          // funct3=0 is only ECALL/EBREAK; nonzero funct3 is the CSR space
          if (f3 != 3'b000) begin
            dec_cls[C_SYSTEM] = 1'b1;
          end else if (i_inst == 32'h0000_0073) begin
            dec_cls[C_SYSTEM] = 1'b1;
            dec_ecall         = 1'b1;
          end else if (i_inst == 32'h0010_0073) begin
            dec_cls[C_SYSTEM] = 1'b1;
            dec_ebreak        = 1'b1;
          end else begin
            dec_ill = 1'b1;
          end
        end
        5'b00011: dec_cls[C_FENCE] = 1'b1;
        default:  dec_ill = 1'b1;
      endcase
    end
  end

  // Register-address gating by class; an illegal instruction has no class bits
  always_comb begin
    dec_rs1 = (dec_cls[C_RTYPE] | dec_cls[C_ITYPE] | dec_cls[C_LOAD] | dec_cls[C_STORE] |
               dec_cls[C_BRANCH] | dec_cls[C_JALR] | dec_cls[C_SYSTEM]) ? i_inst[19:15] : 5'd0;
    dec_rs2 = (dec_cls[C_RTYPE] | dec_cls[C_STORE] | dec_cls[C_BRANCH]) ? i_inst[24:20] : 5'd0;
    dec_rd  = (dec_cls[C_RTYPE] | dec_cls[C_ITYPE] | dec_cls[C_LOAD] | dec_cls[C_JAL] |
               dec_cls[C_JALR] | dec_cls[C_LUI] | dec_cls[C_AUIPC] |
               (dec_cls[C_SYSTEM] && f3 != 3'b000)) ? i_inst[11:7] : 5'd0;
  end

  // Output register: flush beats capture, capture beats stall/retire
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_alu      <= '0;
      o_opcode   <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_rd_addr  <= '0;
      o_imm      <= '0;
      o_funct3   <= '0;
      o_pc       <= '0;
      o_illegal  <= 1'b0;
      o_ecall    <= 1'b0;
      o_ebreak   <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (capture) begin
      o_valid    <= 1'b1;
      o_alu      <= dec_alu;
      o_opcode   <= dec_cls;
      o_rs1_addr <= dec_rs1;
      o_rs2_addr <= dec_rs2;
      o_rd_addr  <= dec_rd;
      o_imm      <= dec_imm;
      o_funct3   <= f3;
      o_pc       <= i_pc;
      o_illegal  <= dec_ill;
      o_ecall    <= dec_ecall;
      o_ebreak   <= dec_ebreak;
    end else if (!i_stall) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_asrv32_decoder.sv
// tb_asrv32_decoder: randomized and directed bench for asrv32_decoder against
// a table-driven reference decoder and a transaction-level handshake model.
`timescale 1ns/1ps
module tb_asrv32_decoder;

  localparam int ADD = 0, SUB = 1, SLT = 2, SLTU = 3, XOR = 4, OR = 5, AND = 6;
  localparam int SLL = 7, SRL = 8, SRA = 9, EQ = 10, NEQ = 11, GE = 12, GEU = 13;

  // Opcodes in class-bit order RTYPE..FENCE
  localparam logic [6:0] OPC [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                      7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
  localparam int RMAP [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
  localparam int BMAP [8] = '{EQ, NEQ, -1, -1, SLT, GE, SLTU, GEU};

  typedef struct packed {
    logic [13:0] alu;
    logic [10:0] opc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic        ill, ec, eb;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] inst = '0, pc = '0;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        o_ready, o_valid, o_illegal, o_ecall, o_ebreak;
  logic [13:0] o_alu;
  logic [10:0] o_opcode;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [31:0] o_imm, o_pc;
  logic [2:0]  o_funct3;

  int   n_chk = 0, n_fail = 0;
  exp_t mexp = '0;
  logic mvalid = 1'b0;

  asrv32_decoder dut (
    .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_pc(pc), .i_valid(valid),
    .o_ready(o_ready), .i_stall(stall), .i_flush(flush), .o_valid(o_valid),
    .o_alu(o_alu), .o_opcode(o_opcode), .o_rs1_addr(o_rs1_addr),
    .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_imm(o_imm),
    .o_funct3(o_funct3), .o_pc(o_pc), .o_illegal(o_illegal),
    .o_ecall(o_ecall), .o_ebreak(o_ebreak)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: class by opcode table lookup, then the legality rules
  function automatic exp_t ref_decode(input logic [31:0] in);
    exp_t        e;
    int          cls, op;
    bit          legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    e = '0;
    f3 = in[14:12];
    f7 = in[31:25];
    cls = -1;
    op = -1;
    for (int k = 0; k < 11; k++) if (in[6:0] == OPC[k]) cls = k;
    legal = (cls >= 0);
    case (cls)
      0: if (f7 == 7'h00) op = RMAP[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) op = SUB;
         else if (f7 == 7'h20 && f3 == 3'd5) op = SRA;
         else legal = 0;
      1: if (f3 == 3'd1 && f7 != 7'h00) legal = 0;
         else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) legal = 0;
         else op = (f3 == 3'd5 && f7 == 7'h20) ? SRA : RMAP[f3];
      2: begin legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); op = ADD; end
      3: begin legal = (f3 <= 3'd2); op = ADD; end
      4: begin op = BMAP[f3]; legal = (op >= 0); end
      5, 7, 8: op = ADD;
      6: begin legal = (f3 == 3'd0); op = ADD; end
      9: if (f3 == 3'd0) legal = (in == 32'h73 || in == 32'h0010_0073);
      default: ;
    endcase
    e.f3 = f3;
    if (!legal) begin
      e.ill = 1'b1;
      return e;
    end
    e.opc[cls] = 1'b1;
    if (op >= 0) e.alu[op] = 1'b1;
    case (cls)
      1, 2, 6: e.imm = 32'(signed'(in[31:20]));
      3:       e.imm = 32'(signed'({in[31:25], in[11:7]}));
      4:       e.imm = 32'(signed'({in[31], in[7], in[30:25], in[11:8], 1'b0}));
      7, 8:    e.imm = in & 32'hFFFF_F000;
      5:       e.imm = 32'(signed'({in[31], in[19:12], in[20], in[30:21], 1'b0}));
      default: e.imm = '0;
    endcase
    if (cls inside {0, 1, 2, 3, 4, 6, 9}) e.rs1 = in[19:15];
    if (cls inside {0, 3, 4}) e.rs2 = in[24:20];
    if (cls inside {0, 1, 2, 5, 6, 7, 8} || (cls == 9 && f3 != 3'd0)) e.rd = in[11:7];
    e.ec = (in == 32'h73);
    e.eb = (in == 32'h0010_0073);
    return e;
  endfunction

  // Drive inputs (away from the edge) and check the combinational ready
  task automatic drive(input bit v, input bit s, input bit f, input logic [31:0] in,
                       input logic [31:0] p);
    valid = v; stall = s; flush = f; inst = in; pc = p;
    #1 check("ready", {63'd0, o_ready}, {63'd0, (!mvalid || !s)});
  endtask

  // One clock: advance the handshake model, then compare outputs at negedge
  task automatic step();
    bit rdy;
    @(posedge clk);
    rdy = !mvalid || !stall;
    if (flush) mvalid = 1'b0;
    else if (valid && rdy) begin
      mexp = ref_decode(inst);
      mexp.pc = pc;
      mvalid = 1'b1;
    end else if (!stall) mvalid = 1'b0;
    @(negedge clk);
    check("valid", {63'd0, o_valid}, {63'd0, mvalid});
    if (mvalid) begin
      check("alu", 64'(o_alu), 64'(mexp.alu));
      check("opcode", 64'(o_opcode), 64'(mexp.opc));
      check("rs1", 64'(o_rs1_addr), 64'(mexp.rs1));
      check("rs2", 64'(o_rs2_addr), 64'(mexp.rs2));
      check("rd", 64'(o_rd_addr), 64'(mexp.rd));
      check("imm", 64'(o_imm), 64'(mexp.imm));
      check("funct3", 64'(o_funct3), 64'(mexp.f3));
      check("pc", 64'(o_pc), 64'(mexp.pc));
      check("flags", {61'd0, o_illegal, o_ecall, o_ebreak}, {61'd0, mexp.ill, mexp.ec, mexp.eb});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    check({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
    check({tag, "_fields"}, 64'(o_alu) | 64'(o_opcode) | 64'(o_rs1_addr) | 64'(o_rs2_addr) |
          64'(o_rd_addr) | 64'(o_imm) | 64'(o_funct3) | 64'(o_pc), 64'd0);
    check({tag, "_flags"}, {61'd0, o_illegal, o_ecall, o_ebreak}, 64'd0);
  endtask

  task automatic one(input logic [31:0] in);
    drive(1, 0, 0, in, 32'h1000);
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: ;
      1: r = $urandom_range(0, 1) ? 32'h73 : 32'h0010_0073;
      default: begin
        r[6:0] = OPC[$urandom_range(0, 10)];
        if ($urandom_range(0, 2) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
    endcase
    return r;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    one(32'h0020_81B3);
    check("add_alu", 64'(o_alu), 64'(1 << ADD));
    check("add_opc", 64'(o_opcode), 64'h1);
    check("add_regs", {49'd0, o_rd_addr, o_rs1_addr, o_rs2_addr}, {49'd0, 5'd3, 5'd1, 5'd2});
    one(32'h4020_81B3);
    check("sub_alu", 64'(o_alu), 64'(1 << SUB));
    one(32'hFFF0_0293);
    check("addi_alu", 64'(o_alu), 64'(1 << ADD));
    check("addi_opc", 64'(o_opcode), 64'h2);
    check("addi_imm", 64'(o_imm), 64'hFFFF_FFFF);
    check("addi_rd_rs2", {54'd0, o_rd_addr, o_rs2_addr}, {54'd0, 5'd5, 5'd0});
    one(32'h4043_D313);
    check("srai_alu", 64'(o_alu), 64'(1 << SRA));
    check("srai_regs", {49'd0, o_rd_addr, o_rs1_addr, o_imm[4:0]}, {49'd0, 5'd6, 5'd7, 5'd4});
    one(32'hFE20_8EE3);
    check("beq_alu", 64'(o_alu), 64'(1 << EQ));
    check("beq_opc", 64'(o_opcode), 64'h10);
    check("beq_imm", 64'(o_imm), 64'hFFFF_FFFC);
    check("beq_rd", 64'(o_rd_addr), 64'd0);
    one(32'h0000_0000);
    check("zero_ill", {62'd0, o_illegal, |{o_alu, o_opcode}}, 64'd2);
    one(32'h0000_0073);
    check("ecall", {61'd0, o_ecall, o_ebreak, o_illegal}, 64'd4);
    one(32'h0010_0073);
    check("ebreak", {61'd0, o_ecall, o_ebreak, o_illegal}, 64'd2);
    one(32'h0000_A003);
    check("lw_legal", {63'd0, o_illegal}, 64'd0);
    one(32'h0000_B003);
    check("ld_illegal", {63'd0, o_illegal}, 64'd1);

    // Back-to-back stream
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, rand_inst(), 32'h2000 + 32'(4 * k));
      step();
      check("stream_pc", 64'(o_pc), 64'h2000 + 64'(4 * k));
    end

    // Stall with a held instruction and a waiting one
    drive(1, 0, 0, 32'h0020_81B3, 32'h3000);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 32'h4020_81B3, 32'h3004);
      step();
      check("stall_pc", 64'(o_pc), 64'h3000);
    end
    drive(1, 0, 0, 32'h4020_81B3, 32'h3004);
    step();
    check("release_pc", 64'(o_pc), 64'h3004);

    // Flush wins over capture
    drive(1, 0, 1, 32'h0020_81B3, 32'h4000);
    step();
    check("flush_valid", {63'd0, o_valid}, 64'd0);

    // Asynchronous reset while stalled
    drive(1, 0, 0, 32'hFFF0_0293, 32'h5000);
    step();
    drive(1, 1, 0, 32'hFFF0_0293, 32'h5004);
    step();
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    mvalid = 1'b0;
    mexp = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            rand_inst(), $urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
